// File: rtl/iic_init_seq_if.sv
// Handshake between the register-init sequencer and the I2C master driver.
// The sequencer is the master side; the driver is the slave side.
interface iic_init_seq_if;
  logic        drv_start_en;
  logic        drv_wr_rd_flag;
  logic [7:0]  drv_dev_addr;
  logic [15:0] drv_register;
  logic [7:0]  drv_data;
  logic        drv_busy;
  logic        drv_err;
  logic [7:0]  drv_rd_data;

  modport master (
    output drv_start_en, drv_wr_rd_flag, drv_dev_addr, drv_register, drv_data,
    input  drv_busy, drv_err, drv_rd_data
  );

  modport slave (
    input  drv_start_en, drv_wr_rd_flag, drv_dev_addr, drv_register, drv_data,
    output drv_busy, drv_err, drv_rd_data
  );
endinterface

// File: rtl/iic_init_seq.sv
// Register-initialisation sequencer: walks a {reg, data} table, issues one
// I2C driver transaction per entry, handles delays, retries and read-back.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | table address applied, waiting for table read latency
// DECODE    | classify entry: end marker, delay or register write
// WAIT_FREE | wait for driver to go idle
// ISSUE     | one-cycle start pulse to driver
// WAIT_ACC  | wait for driver to accept (busy rises), bounded by ACCEPT_TO
// WAIT_DONE | wait for driver busy to fall, sample err / read data
// CHECK     | judge attempt: advance, verify, retry or fail
// DELAY     | timed wait for delay entries
// NEXT      | advance to next table entry
// DONE      | table completed
// FAIL      | sequence aborted on an entry
module iic_init_seq #(
  parameter logic [7:0] DEV_ADDR   = 8'h78,
  parameter int         TBL_AW     = 8,
  parameter int         MAX_RETRY  = 3,
  parameter int         DELAY_UNIT = 800,
  parameter int         ACCEPT_TO  = 64,
  parameter int         VERIFY     = 0
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  iic_init_seq_if.master    drv,
  output logic              busy,
  output logic              init_done,
  output logic              init_fail,
  output logic [TBL_AW-1:0] fail_index
);

  localparam int DLY_W = 8 + $clog2(DELAY_UNIT);
  localparam int ACC_W = $clog2(ACCEPT_TO + 1);
  localparam int TMR_W = (DLY_W > ACC_W) ? DLY_W : ACC_W;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [15:0] REG_DELAY = 16'hFFFF;
  localparam logic [15:0] REG_END   = 16'hFFFE;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WAIT_FREE, S_ISSUE, S_WAIT_ACC,
    S_WAIT_DONE, S_CHECK, S_DELAY, S_NEXT, S_DONE, S_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [RTY_W-1:0]  rty_q, rty_d;
  logic              rd_ph_q, rd_ph_d;
  logic [15:0]       reg_q, reg_d;
  logic [7:0]        dat_q, dat_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              err_q, err_d;
  logic [7:0]        rdat_q, rdat_d;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rty_q   <= '0;
      rd_ph_q <= 1'b0;
      reg_q   <= '0;
      dat_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rty_q   <= rty_d;
      rd_ph_q <= rd_ph_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rty_d   = rty_q;
    rd_ph_d = rd_ph_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          idx_d   = '0;
          rty_d   = '0;
          rd_ph_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (tbl_data[23:8] == REG_END) begin
          state_d = S_DONE;
        end else if (tbl_data[23:8] == REG_DELAY) begin
          tmr_d   = TMR_W'(tbl_data[7:0]) * TMR_W'(DELAY_UNIT);
          state_d = (tbl_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
        end else begin
          reg_d   = tbl_data[23:8];
          dat_d   = tbl_data[7:0];
          state_d = S_WAIT_FREE;
        end
      end
      S_WAIT_FREE: begin
        if (!drv.drv_busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tmr_d   = TMR_W'(ACCEPT_TO - 1);
        state_d = S_WAIT_ACC;
      end
      S_WAIT_ACC: begin
        // A driver that never accepts is treated like a NACK.
        if (drv.drv_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!drv.drv_busy) begin
          err_d   = drv.drv_err;
          rdat_d  = drv.drv_rd_data;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!err_q && (!rd_ph_q || rdat_q == dat_q)) begin
          if (!rd_ph_q && VERIFY != 0) begin
            rd_ph_d = 1'b1;
            state_d = S_WAIT_FREE;
          end else begin
            state_d = S_NEXT;
          end
        end else if (rty_q < RTY_W'(MAX_RETRY)) begin
          rty_d   = rty_q + RTY_W'(1);
          rd_ph_d = 1'b0;
          state_d = S_WAIT_FREE;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_DELAY: begin
        if (tmr_q == '0) state_d = S_NEXT;
        else             tmr_d = tmr_q - TMR_W'(1);
      end
      S_NEXT: begin
        rty_d   = '0;
        rd_ph_d = 1'b0;
        if (idx_q == '1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + TBL_AW'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction fields come straight from registers that only change
  // outside ISSUE..CHECK, so the driver may sample them late.
  assign drv.drv_start_en   = (state_q == S_ISSUE);
  assign drv.drv_wr_rd_flag = rd_ph_q;
  assign drv.drv_dev_addr   = DEV_ADDR;
  assign drv.drv_register   = reg_q;
  assign drv.drv_data       = dat_q;

  assign tbl_addr   = idx_q;
  assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign init_done  = (state_q == S_DONE);
  assign init_fail  = (state_q == S_FAIL);
  assign fail_index = init_fail ? idx_q : '0;

endmodule

// File: tb/tb_iic_init_seq.sv
// Bench for iic_init_seq: two instances (VERIFY = 0 and 1), each with a table
// memory and a behavioural I2C driver model; start pulses are scoreboarded.
module tb_iic_init_seq;

  typedef struct {
    logic        rd;
    logic [15:0] rg;
    logic [7:0]  dt;
    int          cyc;
  } txn_t;

  localparam int BOOT = 20;
  localparam int LAT  = 8;

  logic       clk_i;
  logic       rst_n;
  logic       start_i    [2];
  logic [7:0] tbl_addr_w [2];
  logic [23:0] tbl_data_w [2];
  logic       busy_w     [2];
  logic       done_w     [2];
  logic       fail_w     [2];
  logic [7:0] fidx_w     [2];

  logic [23:0] mem [2][256];
  int nack_idx [2];
  int nack_lim [2];
  int bad_rd   [2];
  bit no_acc   [2];

  txn_t obs_q [2][$];
  txn_t exp_q [2][$];
  int   fall_q [2][$];
  int   boot_fall [2];
  int   cyc = 0;

  int total = 0;
  int bad   = 0;

  iic_init_seq_if bus [2] ();

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    iic_init_seq #(.VERIFY(g)) u_dut (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .start      (start_i[g]),
      .tbl_addr   (tbl_addr_w[g]),
      .tbl_data   (tbl_data_w[g]),
      .drv        (bus[g]),
      .busy       (busy_w[g]),
      .init_done  (done_w[g]),
      .init_fail  (fail_w[g]),
      .fail_index (fidx_w[g])
    );

    always @(posedge clk_i) tbl_data_w[g] <= mem[g][tbl_addr_w[g]];

    int         lat_q, boot_q, nacks_q, badrd_q;
    logic       busy_q, err_q, perr_q;
    logic [7:0] rd_q, last_wr_q;

    // Driver model: busy out of reset for BOOT cycles, LAT cycles per transaction.
    always @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        busy_q <= 1'b1; boot_q <= BOOT; lat_q <= 0; nacks_q <= 0; badrd_q <= 0;
        err_q <= 1'b0; perr_q <= 1'b0; rd_q <= 8'h00; last_wr_q <= 8'h00;
      end else if (boot_q > 0) begin
        boot_q <= boot_q - 1;
        if (boot_q == 1) begin
          busy_q <= 1'b0;
          boot_fall[g] <= cyc;
        end
      end else if (lat_q > 0) begin
        lat_q <= lat_q - 1;
        if (lat_q == 1) begin
          busy_q <= 1'b0;
          err_q  <= perr_q;
          fall_q[g].push_back(cyc);
        end
      end else if (bus[g].drv_start_en && !no_acc[g]) begin
        busy_q <= 1'b1;
        lat_q  <= LAT;
        if (bus[g].drv_wr_rd_flag) begin
          perr_q <= 1'b0;
          rd_q   <= (badrd_q < bad_rd[g]) ? (last_wr_q ^ 8'h01) : last_wr_q;
          if (badrd_q < bad_rd[g]) badrd_q <= badrd_q + 1;
        end else begin
          last_wr_q <= bus[g].drv_data;
          perr_q    <= (int'(tbl_addr_w[g]) == nack_idx[g]) && (nacks_q < nack_lim[g]);
          if ((int'(tbl_addr_w[g]) == nack_idx[g]) && (nacks_q < nack_lim[g]))
            nacks_q <= nacks_q + 1;
        end
      end
    end

    assign bus[g].drv_busy    = busy_q;
    assign bus[g].drv_err     = err_q;
    assign bus[g].drv_rd_data = rd_q;

    always @(negedge clk_i)
      if (bus[g].drv_start_en)
        obs_q[g].push_back('{rd: bus[g].drv_wr_rd_flag, rg: bus[g].drv_register,
                             dt: bus[g].drv_data, cyc: cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk_i);
    start_i[g] = 1'b1;
    @(negedge clk_i);
    start_i[g] = 1'b0;
  endtask

  task automatic clear_tbl(input int g);
    for (int i = 0; i < 256; i++) mem[g][i] = 24'hFFFE00;
  endtask

  task automatic set_ent(input int g, input int i, input logic [15:0] rg, input logic [7:0] dt);
    mem[g][i] = {rg, dt};
  endtask

  task automatic push_exp(input int g, input logic rd, input logic [15:0] rg, input logic [7:0] dt);
    exp_q[g].push_back('{rd: rd, rg: rg, dt: dt, cyc: 0});
  endtask

  task automatic wait_end(input int g, input int budget, input string tag);
    int n = 0;
    while (!(done_w[g] || fail_w[g]) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_finished"}, (n < budget), 1);
  endtask

  task automatic compare_obs(input int g, input int base, input string tag);
    int n_obs;
    int n_exp;
    txn_t e;
    txn_t o;
    n_obs = obs_q[g].size() - base;
    n_exp = exp_q[g].size();
    chk({tag, "_pulses"}, n_obs, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      e = exp_q[g].pop_front();
      if (i < n_obs) begin
        o = obs_q[g][base + i];
        chk($sformatf("%s_txn%0d", tag, i), {7'd0, o.rd, o.rg, o.dt}, {7'd0, e.rd, e.rg, e.dt});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fbase, gap;
    rst_n = 1'b0;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    for (int g = 0; g < 2; g++) begin
      nack_idx[g] = -1; nack_lim[g] = 0; bad_rd[g] = 0; no_acc[g] = 1'b0;
      clear_tbl(g);
    end

    // reset values
    do_reset();
    chk("rst_busy",   busy_w[0], 0);
    chk("rst_done",   done_w[0], 0);
    chk("rst_fail",   fail_w[0], 0);
    chk("rst_fidx",   fidx_w[0], 0);
    chk("rst_taddr",  tbl_addr_w[0], 0);
    chk("rst_sten",   bus[0].drv_start_en, 0);
    chk("rst_devad",  bus[0].drv_dev_addr, 32'h78);
    chk("rst_fields", {bus[0].drv_wr_rd_flag, bus[0].drv_register, bus[0].drv_data}, 0);

    // basic table with a delay entry
    set_ent(0, 0, 16'h3008, 8'h82);
    set_ent(0, 1, 16'hFFFF, 8'h02);
    set_ent(0, 2, 16'h3103, 8'h03);
    set_ent(0, 3, 16'hFFFE, 8'h00);
    base = obs_q[0].size();
    fbase = fall_q[0].size();
    push_exp(0, 1'b0, 16'h3008, 8'h82);
    push_exp(0, 1'b0, 16'h3103, 8'h03);
    pulse_start(0);
    chk("t1_busy_up", busy_w[0], 1);
    repeat (300) @(negedge clk_i);
    pulse_start(0);
    chk("t1_start_ignored", tbl_addr_w[0], 1);
    wait_end(0, 6000, "t1");
    chk("t1_done", done_w[0], 1);
    chk("t1_busy", busy_w[0], 0);
    chk("t1_fail", fail_w[0], 0);
    if (obs_q[0].size() >= base + 2 && fall_q[0].size() > fbase)
      gap = obs_q[0][base + 1].cyc - fall_q[0][fbase];
    else
      gap = 0;
    chk("t1_gap_ge_1600", (gap >= 1600), 1);
    compare_obs(0, base, "t1");

    // entry 1 NACKed twice, restarted straight from DONE
    clear_tbl(0);
    set_ent(0, 0, 16'h1000, 8'h11);
    set_ent(0, 1, 16'h1001, 8'h22);
    nack_idx[0] = 1; nack_lim[0] = 2;
    base = obs_q[0].size();
    push_exp(0, 1'b0, 16'h1000, 8'h11);
    repeat (3) push_exp(0, 1'b0, 16'h1001, 8'h22);
    pulse_start(0);
    chk("t2_done_cleared", done_w[0], 0);
    wait_end(0, 2000, "t2");
    chk("t2_done", done_w[0], 1);
    chk("t2_fail", fail_w[0], 0);
    compare_obs(0, base, "t2");

    // entry 2 always NACKed: retries exhausted
    do_reset();
    clear_tbl(0);
    set_ent(0, 0, 16'h2000, 8'h01);
    set_ent(0, 1, 16'h2001, 8'h02);
    set_ent(0, 2, 16'h2002, 8'h03);
    nack_idx[0] = 2; nack_lim[0] = 1000;
    base = obs_q[0].size();
    push_exp(0, 1'b0, 16'h2000, 8'h01);
    push_exp(0, 1'b0, 16'h2001, 8'h02);
    repeat (4) push_exp(0, 1'b0, 16'h2002, 8'h03);
    pulse_start(0);
    wait_end(0, 2000, "t3");
    chk("t3_fail", fail_w[0], 1);
    chk("t3_fidx", fidx_w[0], 2);
    chk("t3_done", done_w[0], 0);
    chk("t3_busy", busy_w[0], 0);
    repeat (200) @(negedge clk_i);
    compare_obs(0, base, "t3");
    nack_idx[0] = -1; nack_lim[0] = 0;

    // read-back verify: first read mismatches
    do_reset();
    set_ent(1, 0, 16'h4300, 8'h30);
    set_ent(1, 1, 16'hFFFE, 8'h00);
    bad_rd[1] = 1;
    base = obs_q[1].size();
    push_exp(1, 1'b0, 16'h4300, 8'h30);
    push_exp(1, 1'b1, 16'h4300, 8'h30);
    push_exp(1, 1'b0, 16'h4300, 8'h30);
    push_exp(1, 1'b1, 16'h4300, 8'h30);
    pulse_start(1);
    wait_end(1, 2000, "t4");
    chk("t4_done", done_w[1], 1);
    chk("t4_fail", fail_w[1], 0);
    compare_obs(1, base, "t4");

    // driver never accepts: accept timeout on every attempt
    do_reset();
    clear_tbl(0);
    set_ent(0, 0, 16'h2000, 8'h55);
    no_acc[0] = 1'b1;
    base = obs_q[0].size();
    repeat (4) push_exp(0, 1'b0, 16'h2000, 8'h55);
    pulse_start(0);
    wait_end(0, 2000, "t5");
    chk("t5_fail", fail_w[0], 1);
    chk("t5_fidx", fidx_w[0], 0);
    if (obs_q[0].size() >= base + 2) gap = obs_q[0][base + 1].cyc - obs_q[0][base].cyc;
    else gap = 0;
    chk("t5_retry_spacing_ge_64", (gap >= 64), 1);
    compare_obs(0, base, "t5");
    no_acc[0] = 1'b0;

    // reset while waiting for the driver to finish
    do_reset();
    clear_tbl(0);
    set_ent(0, 0, 16'h3008, 8'h82);
    set_ent(0, 1, 16'hFFFF, 8'h02);
    set_ent(0, 2, 16'h3103, 8'h03);
    base = obs_q[0].size();
    pulse_start(0);
    gap = 0;
    while (!(obs_q[0].size() > base && bus[0].drv_busy && busy_w[0]) && gap < 200) begin
      @(negedge clk_i);
      gap++;
    end
    chk("t6_reached_wait_done", (gap < 200), 1);
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  busy_w[0], 0);
    chk("t6_rst_taddr", tbl_addr_w[0], 0);
    chk("t6_rst_sten",  bus[0].drv_start_en, 0);
    chk("t6_rst_reg",   bus[0].drv_register, 0);
    @(negedge clk_i);
    rst_n = 1'b1;
    base = obs_q[0].size();
    push_exp(0, 1'b0, 16'h3008, 8'h82);
    push_exp(0, 1'b0, 16'h3103, 8'h03);
    pulse_start(0);
    chk("t6_taddr_restart", tbl_addr_w[0], 0);
    wait_end(0, 6000, "t6");
    chk("t6_done", done_w[0], 1);
    if (obs_q[0].size() > base) gap = obs_q[0][base].cyc - boot_fall[0];
    else gap = 0;
    chk("t6_first_start_after_drv_idle", (gap > 0), 1);
    compare_obs(0, base, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iic_init_seq.md
Name: iic_init_seq

Overview:
- Register-initialisation sequencer sitting directly above the I2C master driver (16-bit register address, 8-bit data).
- Walks a configuration table, issues one driver transaction per entry and inserts programmable delays.
- Retries NACKed entries, optionally reads back each written register to verify it.
- Reports completion or failure to the system controller.

Parameters:
DEV_ADDR, 8'h78, 8-bit device address driven to the driver (bit 0 ignored by driver)
TBL_AW, 8, table address width; max 2^TBL_AW entries
MAX_RETRY, 3, retries per entry after first attempt fails (err or verify mismatch)
DELAY_UNIT, 800, clk_i cycles per delay tick (1 ms at 0.8 MHz)
ACCEPT_TO, 64, clk_i cycles allowed for drv_busy to rise after a start pulse
VERIFY, 0, 1 = read back each written register and compare

Ports:
clk_i  in  1  driver-rate clock, same clock as the I2C driver
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; begins sequence from entry 0 (ignored unless IDLE/DONE/FAIL)
tbl_addr  out  TBL_AW  table entry index
tbl_data  in  24  {reg[15:0], data[7:0]}; valid one cycle after tbl_addr changes
drv_start_en  out  1  one-cycle transaction request to driver
drv_wr_rd_flag  out  1  0 write, 1 read
drv_dev_addr  out  8  = DEV_ADDR
drv_register  out  16  register address
drv_data  out  8  write data
drv_busy  in  1  driver busy
drv_err  in  1  driver NACK flag, valid when busy falls
drv_rd_data  in  8  read data, valid when busy falls
busy  out  1  sequence in progress
init_done  out  1  level; table completed successfully
init_fail  out  1  level; sequence aborted
fail_index  out  TBL_AW  index of failing entry (valid with init_fail)

Behaviour:
- Reset values: all outputs 0 except drv_dev_addr = DEV_ADDR. tbl_addr = 0. State = IDLE.
- Table encoding:
  - reg = 16'hFFFF: delay entry; wait data×DELAY_UNIT cycles; data = 0 means no wait.
  - reg = 16'hFFFE: end marker.
  - Any other value: register write.
- End condition: index wrap past 2^TBL_AW-1 without an end marker is treated as end.
- States:
  - IDLE: on start -> FETCH, with index = 0, retry count = 0, init_done/init_fail cleared, busy = 1.
  - FETCH: one cycle wait for table latency -> DECODE.
  - DECODE: latch tbl_data.
    - End marker -> DONE.
    - Delay entry -> DELAY.
    - Otherwise -> WAIT_FREE.
  - WAIT_FREE: hold until drv_busy = 0. The driver's busy is 1 out of reset, so the first transaction waits here. Then -> ISSUE.
  - ISSUE: drv_start_en = 1 for exactly one cycle.
    - Outputs: drv_register/drv_data from the latched entry; drv_wr_rd_flag = 0, or 1 during the verify read.
    - Next state -> WAIT_ACC.
  - WAIT_ACC: wait for drv_busy = 1 -> WAIT_DONE. If ACCEPT_TO cycles pass first -> count as failed attempt.
  - WAIT_DONE: on drv_busy falling -> CHECK. drv_err and drv_rd_data are sampled on the same cycle.
  - CHECK:
    - Write phase, err = 0: if VERIFY = 0 -> NEXT; else -> WAIT_FREE with read flag set.
    - Read phase, err = 0 and drv_rd_data == data -> NEXT.
    - Any err, timeout or mismatch: retry count < MAX_RETRY -> increment retry count, restart entry from its write phase via WAIT_FREE. Otherwise -> FAIL.
  - DELAY: down-counter of 8+clog2(DELAY_UNIT) bits -> NEXT at zero.
  - NEXT: index+1, retry count = 0, read flag cleared. At index 2^TBL_AW-1 -> DONE, else -> FETCH.
  - DONE: init_done = 1, busy = 0.
  - FAIL: init_fail = 1, fail_index = current index, busy = 0.
  - DONE/FAIL + start -> restart as from IDLE; flags cleared the cycle start is accepted.
- Outputs: drv_register/drv_data/drv_wr_rd_flag are held stable from ISSUE until CHECK (the driver samples them late).
- start while busy: ignored.
- Reset mid-transaction: sequencer returns to IDLE immediately. Because the driver shares rst_n, no bus recovery is attempted.

Test Plan:
- Table {0x3008:0x82, 0xFFFF:0x02, 0x3103:0x03, 0xFFFE}, driver model ACKs all. Required response:
  - Exactly 2 drv_start_en pulses, carrying register 0x3008/data 0x82 then 0x3103/0x03.
  - Gap of ≥1600 cycles between first busy fall and second start.
  - init_done = 1, busy = 0.
- Driver model NACKs entry 1 twice then ACKs (MAX_RETRY = 3) -> 4 start pulses total, init_done = 1, init_fail = 0.
- Driver model always NACKs entry 2 -> 1+3 attempts on entry 2, init_fail = 1, fail_index = 2, no further starts.
- VERIFY = 1, entry 0x4300:0x30, read returns 0x31 then 0x30 -> required pulse sequence: write, read, write, read (wr_rd_flag = 0,1,0,1); init_done = 1.
- Driver model never raises busy after start -> timeout after ACCEPT_TO cycles, retried, then init_fail = 1 with fail_index = 0.
- Assert rst_n low while in WAIT_DONE, release, pulse start -> outputs at reset values, sequence restarts from tbl_addr = 0, first start waits for drv_busy = 0.
